ram_port_arb: RTL and testbench
===============================

Name: ram_port_arb

Overview:
- Shares the single-port byte-wide main RAM between two requesters: the CPU memory port and the VDT text-refresh fetcher.
- Sits between both requesters and the synchronous RAM array, which has a 1-cycle read latency.
- CPU has fixed priority. A starvation guard guarantees the video fetcher a slot after a bounded wait.
- Write accesses outside the RAM depth are suppressed.

Parameters:
- ADDR_W, 16, address width of both requesters and the RAM port.
- RAM_DEPTH, 26624, number of implemented bytes. Valid addresses are 0 to RAM_DEPTH-1.
- MAX_WAIT, 4, consecutive denied cycles of a pending vid_req before video is forced a grant (range 1..15).
- WPROT_BASE, 16'h6000, first write-protected address. Used only with the optional feature.

Ports:
- CLOCK  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid (1 cycle after read grant)
- cpu_rdata  out  8  CPU read data
- vid_req  in  1  video read request, held until vid_gnt
- vid_addr  in  ADDR_W  video byte address
- vid_gnt  out  1  video access accepted this cycle
- vid_rvalid  out  1  video read data valid
- vid_rdata  out  8  video read data
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM registered read data, valid the cycle after the address is presented
- wprot_err  out  1  1-cycle pulse on a dropped protected write (optional feature only)

Behaviour:
- Reset values: cpu_gnt=0, vid_gnt=0, cpu_rvalid=0, vid_rvalid=0, ram_we=0, ram_addr=0, ram_din=0, wprot_err=0, starvation counter wcnt=0, forced flag vforce=0.
- During RESET both grants are held 0 regardless of requests.
- Arbitration is combinational within the cycle, one access per cycle:
  - vforce=1 and vid_req=1: grant video.
  - else cpu_req=1: grant CPU.
  - else vid_req=1: grant video.
  - else: idle.
- Exactly one of cpu_gnt/vid_gnt is 1 when any request is pending. They are never both 1.
- RAM drive:
  - ram_addr is the granted requester's address; when idle it holds the last value.
  - ram_we = cpu_gnt & cpu_we & (cpu_addr < RAM_DEPTH).
  - ram_din = cpu_wdata when the CPU is granted, else 0.
  - Video never writes.
- Read return:
  - The granted-read owner is registered into a 2-bit tag.
  - The next cycle, the owner's rvalid=1 and its rdata = ram_dout.
  - If the read address was >= RAM_DEPTH, rdata = 8'h00.
  - rdata is a don't-care when rvalid=0; the bench checks it only on rvalid.
- Back-to-back grants are allowed every cycle. A read grant in cycle N and any grant in N+1 do not interfere: the rvalid of N appears in N+1 alongside the new grant.
- Starvation guard:
  - wcnt increments each cycle with vid_req=1 and vid_gnt=0, saturating at MAX_WAIT.
  - wcnt clears when vid_gnt=1 or vid_req=0.
  - vforce is combinational: (wcnt == MAX_WAIT).
  - A forced video grant stalls the CPU exactly one cycle; cpu_gnt=0 that cycle.
- A requester dropping req before gnt is legal; no state is kept for it.
- Reset mid-read: a pending rvalid is cancelled, so no rvalid appears in the cycle after RESET.

Optional Feature:
- RAM_PORT_ARB_WPROT_EN defined:
  - A CPU write with cpu_addr >= WPROT_BASE is still granted (cpu_gnt=1) but ram_we=0.
  - wprot_err pulses 1 the following cycle.
- Not defined: WPROT_BASE is ignored, wprot_err is tied 0, and only the RAM_DEPTH bound gates ram_we.

Test Plan:
- CPU write 0x0123←8'hA5, then CPU read 0x0123 → cpu_gnt each cycle, ram_we=1 only in the first, cpu_rvalid=1 with cpu_rdata=8'hA5 one cycle after the read grant.
- vid_req only, address 0x0010 (RAM holds 8'h3C) → vid_gnt the same cycle, vid_rvalid next cycle with vid_rdata=8'h3C, no cpu_rvalid.
- cpu_req and vid_req held continuously, MAX_WAIT=4 → CPU granted 4 cycles, video granted on cycle 5, CPU resumes on cycle 6, pattern repeats (period 5).
- Simultaneous single-cycle cpu_req read and vid_req → CPU granted first, video the next cycle, rvalids in consecutive cycles for the correct owners.
- CPU write at 0x7000 with RAM_DEPTH=26624 → cpu_gnt=1, ram_we=0. A read at 0x7000 returns cpu_rdata=8'h00.
- RESET asserted the cycle after a CPU read grant → no cpu_rvalid. With the feature enabled, a write at 0x6000 afterwards gives cpu_gnt=1, ram_we=0, and a wprot_err pulse.

Source files
------------

// File: rtl/ram_port_arb_if.sv
// Bus bundle between the CPU port, the VDT fetcher, the RAM array and ram_port_arb.
// master = requesters/RAM side, slave = the arbiter.
interface ram_port_arb_if #(
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [7:0]        cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [7:0]        vid_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  logic              wprot_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
    input  ram_addr, ram_we, ram_din, wprot_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
    output ram_addr, ram_we, ram_din, wprot_err
  );
endinterface

// File: rtl/ram_port_arb.sv
// Main-RAM port arbiter: CPU fixed priority, video starvation guard, 1-cycle read return.
// Optional write protection above WPROT_BASE is enabled by defining RAM_PORT_ARB_WPROT_EN.
module ram_port_arb #(
  parameter int                ADDR_W     = 16,
  parameter int                RAM_DEPTH  = 26624,
  parameter int                MAX_WAIT   = 4,
  parameter logic [ADDR_W-1:0] WPROT_BASE = 16'h6000
) (
  input  logic           CLOCK,
  input  logic           RESET,
  ram_port_arb_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_L = RAM_DEPTH[ADDR_W:0];
  localparam logic [3:0]      WAIT_L  = MAX_WAIT[3:0];

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_VID  = 2'd2
  } rd_owner_t;

  rd_owner_t         rd_q, rd_d;
  logic              rd_oob_q, rd_oob_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ram_addr_c;
  logic              vforce;
  logic              cpu_gnt, vid_gnt;
  logic              cpu_in_range, vid_in_range;
  logic              prot_hit;
  logic              ram_we_c;

  assign cpu_in_range = {1'b0, bus.cpu_addr} < DEPTH_L;
  assign vid_in_range = {1'b0, bus.vid_addr} < DEPTH_L;
  assign vforce       = (wcnt_q == WAIT_L);

`ifdef RAM_PORT_ARB_WPROT_EN
  logic wprot_q;
  assign prot_hit = (bus.cpu_addr >= WPROT_BASE);

  always_ff @(posedge CLOCK) begin
    if (RESET) wprot_q <= 1'b0;
    else       wprot_q <= cpu_gnt & bus.cpu_we & prot_hit;
  end
  assign bus.wprot_err = wprot_q;
`else
  logic [ADDR_W-1:0] unused_wprot_base;
  assign unused_wprot_base = WPROT_BASE;
  assign prot_hit          = 1'b0;
  assign bus.wprot_err     = 1'b0;
`endif

  // Arbitration and next-state for read-return owner and starvation counter.
  always_comb begin
    cpu_gnt  = 1'b0;
    vid_gnt  = 1'b0;
    rd_d     = RD_NONE;
    rd_oob_d = 1'b0;
    wcnt_d   = wcnt_q;

    if (!RESET) begin
      if (vforce && bus.vid_req) vid_gnt = 1'b1;
      else if (bus.cpu_req)      cpu_gnt = 1'b1;
      else if (bus.vid_req)      vid_gnt = 1'b1;
    end

    if (cpu_gnt && !bus.cpu_we) begin
      rd_d     = RD_CPU;
      rd_oob_d = ~cpu_in_range;
    end else if (vid_gnt) begin
      rd_d     = RD_VID;
      rd_oob_d = ~vid_in_range;
    end

    if (!bus.vid_req || vid_gnt) wcnt_d = '0;
    else if (wcnt_q != WAIT_L)   wcnt_d = wcnt_q + 4'd1;

    ram_we_c = cpu_gnt & bus.cpu_we & cpu_in_range & ~prot_hit;

    if (cpu_gnt)      ram_addr_c = bus.cpu_addr;
    else if (vid_gnt) ram_addr_c = bus.vid_addr;
    else              ram_addr_c = addr_q;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_q     <= RD_NONE;
      rd_oob_q <= 1'b0;
      wcnt_q   <= '0;
      addr_q   <= '0;
    end else begin
      rd_q     <= rd_d;
      rd_oob_q <= rd_oob_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= ram_addr_c;
    end
  end

  assign bus.cpu_gnt  = cpu_gnt;
  assign bus.vid_gnt  = vid_gnt;
  assign bus.ram_addr = ram_addr_c;
  assign bus.ram_we   = ram_we_c;
  assign bus.ram_din  = cpu_gnt ? bus.cpu_wdata : '0;

  // rvalid is masked by RESET so a read granted just before reset never returns.
  assign bus.cpu_rvalid = (rd_q == RD_CPU) & ~RESET;
  assign bus.vid_rvalid = (rd_q == RD_VID) & ~RESET;
  assign bus.cpu_rdata  = rd_oob_q ? '0 : bus.ram_dout;
  assign bus.vid_rdata  = rd_oob_q ? '0 : bus.ram_dout;

endmodule

// File: tb/tb_ram_port_arb.sv
// Self-checking bench for ram_port_arb: directed scenarios plus a randomized run
// against a shadow-memory reference model. Includes a behavioural 1-cycle RAM.
module tb_ram_port_arb;
  localparam int          ADDR_W     = 16;
  localparam int          RAM_DEPTH  = 26624;
  localparam int          MAX_WAIT   = 4;
  localparam logic [15:0] WPROT_BASE = 16'h6000;
`ifdef RAM_PORT_ARB_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic init_mem = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [7:0] mem    [RAM_DEPTH];
  logic [7:0] shadow [RAM_DEPTH];

  always #5 CLOCK = ~CLOCK;

  ram_port_arb_if #(.ADDR_W(ADDR_W)) bus ();

  ram_port_arb #(
    .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH), .MAX_WAIT(MAX_WAIT), .WPROT_BASE(WPROT_BASE)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .bus(bus)
  );

  function automatic logic [7:0] pat(input int a);
    return (a == 16) ? 8'h3C : 8'(a * 7 + 3);
  endfunction

  // Synchronous RAM array: registered read, out-of-range reads return garbage.
  always @(posedge CLOCK) begin
    if (init_mem) begin
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= pat(i);
    end else begin
      if (bus.ram_we && int'(bus.ram_addr) < RAM_DEPTH) mem[bus.ram_addr] <= bus.ram_din;
      if (int'(bus.ram_addr) < RAM_DEPTH) bus.ram_dout <= mem[bus.ram_addr];
      else bus.ram_dout <= 8'($urandom);
    end
  end

  task automatic set_cpu(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_vid(input logic req, input logic [15:0] a);
    bus.vid_req = req; bus.vid_addr = a;
  endtask

  task automatic next_cycle;
    @(posedge CLOCK); #1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 3:    return 16'($urandom_range(0, 255));
      1:       return 16'($urandom_range(24572, 24579));
      default: return 16'($urandom_range(RAM_DEPTH - 4, RAM_DEPTH + 3));
    endcase
  endfunction

  task automatic test_reset;
    RESET = 1'b1; init_mem = 1'b1;
    set_cpu(1'b1, 1'b1, 16'h0055, 8'h99); set_vid(1'b1, 16'h0066);
    next_cycle;
    init_mem = 1'b0;
    @(negedge CLOCK);
    total++; if (bus.cpu_gnt !== 1'b0) begin bad++; $display("FAIL rst_cpu_gnt got=%0h want=0", bus.cpu_gnt); end
    total++; if (bus.vid_gnt !== 1'b0) begin bad++; $display("FAIL rst_vid_gnt got=%0h want=0", bus.vid_gnt); end
    total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we got=%0h want=0", bus.ram_we); end
    total++; if (bus.ram_addr !== 16'h0) begin bad++; $display("FAIL rst_ram_addr got=%0h want=0", bus.ram_addr); end
    total++; if (bus.ram_din !== 8'h0) begin bad++; $display("FAIL rst_ram_din got=%0h want=0", bus.ram_din); end
    total++; if (bus.cpu_rvalid !== 1'b0 || bus.vid_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0h%0h want=00", bus.cpu_rvalid, bus.vid_rvalid); end
    total++; if (bus.wprot_err !== 1'b0) begin bad++; $display("FAIL rst_wprot got=%0h want=0", bus.wprot_err); end
    next_cycle;
    RESET = 1'b0;
    set_cpu(1'b0, 1'b0, 16'h0, 8'h0); set_vid(1'b0, 16'h0);
    next_cycle;
  endtask

  task automatic test_write_read;
    set_cpu(1'b1, 1'b1, 16'h0123, 8'hA5);
    @(negedge CLOCK);
    total++; if (bus.cpu_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%0h want=1", bus.cpu_gnt); end
    total++; if (bus.ram_we !== 1'b1) begin bad++; $display("FAIL wr_we got=%0h want=1", bus.ram_we); end
    total++; if (bus.ram_addr !== 16'h0123) begin bad++; $display("FAIL wr_addr got=%0h want=0123", bus.ram_addr); end
    total++; if (bus.ram_din !== 8'hA5) begin bad++; $display("FAIL wr_din got=%0h want=a5", bus.ram_din); end
    shadow[16'h0123] = 8'hA5;
    next_cycle;
    set_cpu(1'b1, 1'b0, 16'h0123, 8'h00);
    @(negedge CLOCK);
    total++; if (bus.cpu_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%0h want=1", bus.cpu_gnt); end
    total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL rd_we got=%0h want=0", bus.ram_we); end
    total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got=%0h want=0", bus.cpu_rvalid); end
    next_cycle;
    set_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge CLOCK);
    total++; if (bus.cpu_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid got=%0h want=1", bus.cpu_rvalid); end
    total++; if (bus.cpu_rdata !== 8'hA5) begin bad++; $display("FAIL rd_data got=%0h want=a5", bus.cpu_rdata); end
    next_cycle;
  endtask

  task automatic test_video_read;
    set_vid(1'b1, 16'h0010);
    @(negedge CLOCK);
    total++; if (bus.vid_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) begin bad++; $display("FAIL vid_gnt got=%0h%0h want=10", bus.vid_gnt, bus.cpu_gnt); end
    total++; if (bus.ram_addr !== 16'h0010 || bus.ram_we !== 1'b0) begin bad++; $display("FAIL vid_drive got=%0h/%0h want=0010/0", bus.ram_addr, bus.ram_we); end
    next_cycle;
    set_vid(1'b0, 16'h0);
    @(negedge CLOCK);
    total++; if (bus.vid_rvalid !== 1'b1) begin bad++; $display("FAIL vid_rvalid got=%0h want=1", bus.vid_rvalid); end
    total++; if (bus.vid_rdata !== 8'h3C) begin bad++; $display("FAIL vid_rdata got=%0h want=3c", bus.vid_rdata); end
    total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL vid_no_cpu_rvalid got=%0h want=0", bus.cpu_rvalid); end
    total++; if (bus.ram_addr !== 16'h0010) begin bad++; $display("FAIL idle_hold_addr got=%0h want=0010", bus.ram_addr); end
    next_cycle;
  endtask

  task automatic test_starvation;
    logic prev_c;
    prev_c = 1'b0;
    set_cpu(1'b1, 1'b0, 16'h0020, 8'h00); set_vid(1'b1, 16'h0030);
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLOCK);
      total++; if (bus.vid_gnt !== ((k % 5) == 0) || bus.cpu_gnt !== ((k % 5) != 0)) begin
        bad++; $display("FAIL starve_k%0d got=c%0h v%0h want=c%0h v%0h", k, bus.cpu_gnt, bus.vid_gnt, (k % 5) != 0, (k % 5) == 0);
      end
      total++; if (bus.cpu_rvalid !== prev_c) begin bad++; $display("FAIL starve_rvalid_k%0d got=%0h want=%0h", k, bus.cpu_rvalid, prev_c); end
      if (prev_c) begin
        total++; if (bus.cpu_rdata !== shadow[16'h0020]) begin bad++; $display("FAIL starve_rdata_k%0d got=%0h want=%0h", k, bus.cpu_rdata, shadow[16'h0020]); end
      end
      prev_c = ((k % 5) != 0);
      next_cycle;
    end
    set_cpu(1'b0, 1'b0, 16'h0, 8'h0); set_vid(1'b0, 16'h0);
    next_cycle;
  endtask

  task automatic test_simultaneous;
    set_cpu(1'b1, 1'b0, 16'h0040, 8'h00); set_vid(1'b1, 16'h0050);
    @(negedge CLOCK);
    total++; if (bus.cpu_gnt !== 1'b1 || bus.vid_gnt !== 1'b0) begin bad++; $display("FAIL sim_first got=c%0h v%0h want=c1 v0", bus.cpu_gnt, bus.vid_gnt); end
    next_cycle;
    set_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge CLOCK);
    total++; if (bus.vid_gnt !== 1'b1) begin bad++; $display("FAIL sim_second got=%0h want=1", bus.vid_gnt); end
    total++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== shadow[16'h0040]) begin bad++; $display("FAIL sim_cpu_ret got=%0h/%0h want=1/%0h", bus.cpu_rvalid, bus.cpu_rdata, shadow[16'h0040]); end
    next_cycle;
    set_vid(1'b0, 16'h0);
    @(negedge CLOCK);
    total++; if (bus.vid_rvalid !== 1'b1 || bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL sim_vid_owner got=v%0h c%0h want=v1 c0", bus.vid_rvalid, bus.cpu_rvalid); end
    total++; if (bus.vid_rdata !== shadow[16'h0050]) begin bad++; $display("FAIL sim_vid_data got=%0h want=%0h", bus.vid_rdata, shadow[16'h0050]); end
    next_cycle;
  endtask

  task automatic test_out_of_range;
    set_cpu(1'b1, 1'b1, 16'h7000, 8'hEE);
    @(negedge CLOCK);
    total++; if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b0) begin bad++; $display("FAIL oob_wr got=g%0h we%0h want=g1 we0", bus.cpu_gnt, bus.ram_we); end
    next_cycle;
    set_cpu(1'b1, 1'b0, 16'h7000, 8'h00);
    @(negedge CLOCK);
    total++; if (bus.cpu_gnt !== 1'b1) begin bad++; $display("FAIL oob_rd_gnt got=%0h want=1", bus.cpu_gnt); end
    total++; if (bus.wprot_err !== WPROT_ON) begin bad++; $display("FAIL oob_wprot got=%0h want=%0h", bus.wprot_err, WPROT_ON); end
    next_cycle;
    set_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge CLOCK);
    total++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h00) begin bad++; $display("FAIL oob_rd_data got=%0h/%0h want=1/00", bus.cpu_rvalid, bus.cpu_rdata); end
    next_cycle;
  endtask

  task automatic test_reset_mid_read;
    set_cpu(1'b1, 1'b0, 16'h0123, 8'h00);
    @(negedge CLOCK);
    total++; if (bus.cpu_gnt !== 1'b1) begin bad++; $display("FAIL rmr_gnt got=%0h want=1", bus.cpu_gnt); end
    next_cycle;
    RESET = 1'b1; set_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge CLOCK);
    total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rmr_rvalid_in_reset got=%0h want=0", bus.cpu_rvalid); end
    next_cycle;
    RESET = 1'b0;
    @(negedge CLOCK);
    total++; if (bus.cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rmr_rvalid_after got=%0h want=0", bus.cpu_rvalid); end
    next_cycle;
    set_cpu(1'b1, 1'b1, 16'h6000, 8'h77);
    @(negedge CLOCK);
    total++; if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== !WPROT_ON) begin bad++; $display("FAIL prot_wr got=g%0h we%0h want=g1 we%0h", bus.cpu_gnt, bus.ram_we, !WPROT_ON); end
    if (!WPROT_ON) shadow[16'h6000] = 8'h77;
    next_cycle;
    set_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge CLOCK);
    total++; if (bus.wprot_err !== WPROT_ON) begin bad++; $display("FAIL prot_err got=%0h want=%0h", bus.wprot_err, WPROT_ON); end
    next_cycle;
  endtask

  // Reference model: grants and returns derived from the priority/starvation rules
  // with a shadow memory holding what the RAM should contain.
  task automatic test_random;
    int          vid_wait;
    logic [15:0] last_addr, ca, va, e_addr;
    logic [7:0]  cd, pend_d, e_din;
    logic        pend_c, pend_v, exp_werr, cr, cw, vr, eg_c, eg_v, e_we, prot, c_in;
    RESET = 1'b1; set_cpu(1'b0, 1'b0, 16'h0, 8'h0); set_vid(1'b0, 16'h0);
    next_cycle;
    RESET = 1'b0;
    vid_wait = 0; last_addr = '0; pend_c = 1'b0; pend_v = 1'b0; pend_d = '0; exp_werr = 1'b0;
    cr = 1'b0; cw = 1'b0; vr = 1'b0; ca = '0; va = '0; cd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!cr || $urandom_range(0, 9) == 0) begin
        cr = ($urandom_range(0, 2) != 0); cw = 1'($urandom_range(0, 1)); ca = rand_addr(); cd = 8'($urandom);
      end
      if (!vr || $urandom_range(0, 9) == 0) begin
        vr = 1'($urandom_range(0, 1)); va = rand_addr();
      end
      set_cpu(cr, cw, ca, cd); set_vid(vr, va);
      eg_v   = vr && (vid_wait >= MAX_WAIT || !cr);
      eg_c   = cr && !eg_v;
      c_in   = int'(ca) < RAM_DEPTH;
      prot   = WPROT_ON && (ca >= WPROT_BASE);
      e_we   = eg_c && cw && c_in && !prot;
      e_addr = eg_c ? ca : (eg_v ? va : last_addr);
      e_din  = eg_c ? cd : 8'h00;
      @(negedge CLOCK);
      total++; if (bus.cpu_gnt !== eg_c || bus.vid_gnt !== eg_v) begin bad++; $display("FAIL rnd_gnt n=%0d got=c%0h v%0h want=c%0h v%0h", n, bus.cpu_gnt, bus.vid_gnt, eg_c, eg_v); end
      total++; if (bus.ram_we !== e_we) begin bad++; $display("FAIL rnd_we n=%0d got=%0h want=%0h", n, bus.ram_we, e_we); end
      total++; if (bus.ram_addr !== e_addr || bus.ram_din !== e_din) begin bad++; $display("FAIL rnd_drive n=%0d got=%0h/%0h want=%0h/%0h", n, bus.ram_addr, bus.ram_din, e_addr, e_din); end
      total++; if (bus.cpu_rvalid !== pend_c || bus.vid_rvalid !== pend_v) begin bad++; $display("FAIL rnd_rvalid n=%0d got=c%0h v%0h want=c%0h v%0h", n, bus.cpu_rvalid, bus.vid_rvalid, pend_c, pend_v); end
      if (pend_c) begin
        total++; if (bus.cpu_rdata !== pend_d) begin bad++; $display("FAIL rnd_cpu_rdata n=%0d got=%0h want=%0h", n, bus.cpu_rdata, pend_d); end
      end
      if (pend_v) begin
        total++; if (bus.vid_rdata !== pend_d) begin bad++; $display("FAIL rnd_vid_rdata n=%0d got=%0h want=%0h", n, bus.vid_rdata, pend_d); end
      end
      total++; if (bus.wprot_err !== exp_werr) begin bad++; $display("FAIL rnd_wprot n=%0d got=%0h want=%0h", n, bus.wprot_err, exp_werr); end
      pend_c = eg_c && !cw;
      pend_v = eg_v;
      if (pend_c)      pend_d = c_in ? shadow[ca] : 8'h00;
      else if (pend_v) pend_d = (int'(va) < RAM_DEPTH) ? shadow[va] : 8'h00;
      if (e_we) shadow[ca] = cd;
      exp_werr  = eg_c && cw && prot;
      vid_wait  = (vr && !eg_v) ? ((vid_wait + 1 > MAX_WAIT) ? MAX_WAIT : vid_wait + 1) : 0;
      last_addr = e_addr;
      if (eg_c) cr = 1'b0;
      if (eg_v) vr = 1'b0;
      next_cycle;
    end
    set_cpu(1'b0, 1'b0, 16'h0, 8'h0); set_vid(1'b0, 16'h0);
    next_cycle;
  endtask

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) shadow[i] = pat(i);
    bus.ram_dout = 8'h00;
    set_cpu(1'b0, 1'b0, 16'h0, 8'h0); set_vid(1'b0, 16'h0);
    test_reset;
    test_write_read;
    test_video_read;
    test_starvation;
    test_simultaneous;
    test_out_of_range;
    test_reset_mid_read;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
